// File: rtl/tile_pkg.sv
// Shared definitions for the tile row renderer: FSM encoding, default 8x8 glyph table
// and the rotate/mirror pixel transform.
package tile_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int unsigned GLYPH_W = 8;

    // Row word of the default glyphs, MSB = leftmost pixel; anything outside the table is blank.
    function automatic logic [GLYPH_W-1:0] glyph_row(int unsigned ty, int unsigned r);
        logic [GLYPH_W-1:0] w;
        w = '0;
        if (r < GLYPH_W) begin
            case (ty)
                32'd1: w = 8'b0001_0000;
                32'd2: begin
                    if (r == 32'd3)      w = 8'b0000_0111;
                    else if (r == 32'd4) w = 8'b0000_1000;
                    else if (r >= 32'd5) w = 8'b0001_0000;
                end
                32'd3: begin
                    if (r == 32'd4)      w = 8'b0000_0011;
                    else if (r == 32'd5) w = 8'b0000_0100;
                    else if (r >= 32'd6) w = 8'b0000_1000;
                end
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    function automatic logic src_pix(int unsigned ty, int unsigned r, int unsigned c);
        logic [GLYPH_W-1:0] w;
        logic               p;
        p = 1'b0;
        if (c < GLYPH_W) begin
            w = glyph_row(ty, r);
            p = w[3'(GLYPH_W - 1 - c)];
        end
        return p;
    endfunction

    // Displayed pixel (r,c) after clockwise rotation, then horizontal mirror.
    function automatic logic xform_pix(int unsigned w, int unsigned ty, int unsigned rot,
                                       logic mirror, int unsigned r, int unsigned c);
        int unsigned cc;
        logic        p;
        cc = mirror ? (w - 1 - c) : c;
        case (rot)
            32'd0:   p = src_pix(ty, r, cc);
            32'd1:   p = src_pix(ty, w - 1 - cc, r);
            32'd2:   p = src_pix(ty, w - 1 - r, w - 1 - cc);
            default: p = src_pix(ty, cc, w - 1 - r);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tile_row_renderer_if.sv
// Request and pixel-stream handshake bundle for the tile row renderer.
interface tile_row_renderer_if #(
    parameter int unsigned TILE_W = 8,
    parameter int unsigned TYPE_W = 2
);
    localparam int unsigned ROW_W = $clog2(TILE_W);

    logic              req_valid;
    logic              req_ready;
    logic [TYPE_W-1:0] req_type;
    logic [1:0]        req_rot;
    logic              req_mirror;
    logic [ROW_W-1:0]  req_row;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_out;
    logic              pix_last;

    modport master (
        output req_valid, req_type, req_rot, req_mirror, req_row, pix_ready,
        input  req_ready, pix_valid, pix_out, pix_last
    );

    modport slave (
        input  req_valid, req_type, req_rot, req_mirror, req_row, pix_ready,
        output req_ready, pix_valid, pix_out, pix_last
    );
endinterface

// File: rtl/tile_xform.sv
// Combinational glyph lookup: one transformed row word, MSB = leftmost displayed pixel.
module tile_xform
    import tile_pkg::*;
#(
    parameter int unsigned TILE_W = 8,
    parameter int unsigned TYPE_W = 2
) (
    input  logic [TYPE_W-1:0]         type_i,
    input  logic [1:0]                rot_i,
    input  logic                      mirror_i,
    input  logic [$clog2(TILE_W)-1:0] row_i,
    output logic [TILE_W-1:0]         row_o
);

    always_comb begin
        row_o = '0;
        for (int unsigned c = 0; c < TILE_W; c++) begin
            row_o[TILE_W-1-c] = xform_pix(TILE_W, 32'(type_i), 32'(rot_i), mirror_i,
                                          32'(row_i), c);
        end
    end

endmodule

// File: rtl/tile_row_renderer.sv
// Streams one row of a rotated/mirrored glyph as serial pixels, leftmost first,
// with back-to-back row chaining on the last pixel.
module tile_row_renderer
    import tile_pkg::*;
#(
    parameter int unsigned TILE_W = 8,
    parameter int unsigned TYPE_W = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    tile_row_renderer_if.slave  bus
);

    localparam int unsigned         CNT_W    = $clog2(TILE_W);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TILE_W - 1);

    logic [0:0]        state_q, state_d;
    logic [TILE_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [TILE_W-1:0] row_word;
    logic              shifting;
    logic              last_c;
    logic              ready_c;
    logic              req_xfer;
    logic              pix_xfer;

    tile_xform #(
        .TILE_W (TILE_W),
        .TYPE_W (TYPE_W)
    ) u_xform (
        .type_i   (bus.req_type),
        .rot_i    (bus.req_rot),
        .mirror_i (bus.req_mirror),
        .row_i    (bus.req_row),
        .row_o    (row_word)
    );

    assign shifting = (state_q == ST_SHIFT);
    assign last_c   = shifting && (cnt_q == CNT_LAST);
    assign ready_c  = !shifting || (last_c && bus.pix_ready);
    assign req_xfer = bus.req_valid && ready_c;
    assign pix_xfer = shifting && bus.pix_ready;

    assign bus.req_ready = ready_c;
    assign bus.pix_valid = shifting;
    assign bus.pix_last  = last_c;
    assign bus.pix_out   = shreg_q[TILE_W-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load on request, shift on non-last pixel, chain or drop back to idle on the last one.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_xfer) begin
                    shreg_d = row_word;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (pix_xfer) begin
                    if (!last_c) begin
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (req_xfer) begin
                        shreg_d = row_word;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_tile_row_renderer.sv
// Bench for tile_row_renderer: directed glyph cases plus random rows against a bitmap-rotation model.
module tb_tile_row_renderer;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tile_row_renderer_if #(.TILE_W(8), .TYPE_W(2)) bus ();

    tile_row_renderer #(.TILE_W(8), .TYPE_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph(int ty, int r);
        logic [7:0] g;
        g = 8'b0;
        case (ty)
            1: g = 8'b0001_0000;
            2: g = (r < 3) ? 8'b0 : (r == 3) ? 8'b0000_0111 : (r == 4) ? 8'b0000_1000 : 8'b0001_0000;
            3: g = (r < 4) ? 8'b0 : (r == 4) ? 8'b0000_0011 : (r == 5) ? 8'b0000_0100 : 8'b0000_1000;
            default: g = 8'b0;
        endcase
        return g;
    endfunction

    // Build the bitmap, turn it 90 degrees clockwise rot times, mirror, pick the row.
    function automatic logic [7:0] model_row(int ty, int rot, bit mir, int row);
        bit         a [8][8];
        bit         b [8][8];
        logic [7:0] g;
        logic [7:0] res;
        for (int r = 0; r < 8; r++) begin
            g = glyph(ty, r);
            for (int c = 0; c < 8; c++) a[r][c] = g[7-c];
        end
        for (int k = 0; k < rot; k++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) b[r][c] = a[7-c][r];
            a = b;
        end
        for (int c = 0; c < 8; c++) res[7-c] = mir ? a[row][7-c] : a[row][c];
        return res;
    endfunction

    task automatic request(input int ty, input int rot, input bit mir, input int row);
        bus.req_valid  = 1'b1;
        bus.req_type   = 2'(ty);
        bus.req_rot    = 2'(rot);
        bus.req_mirror = mir;
        bus.req_row    = 3'(row);
        #1;
        chk1("idle_req_ready", bus.req_ready, 1'b1);
        chk1("idle_pix_valid", bus.pix_valid, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,1...
    task automatic pixels(input logic [7:0] exp, input int mode, input int npix, input bit chain,
                          input int nty, input int nrot, input bit nmir, input int nrow);
        int col = 0;
        int k   = 0;
        while (col < npix && k < 64) begin
            case (mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = ($urandom_range(0, 3) != 0);
                default: bus.pix_ready = !(k == 1 || k == 2);
            endcase
            if (chain && col == 7 && bus.pix_ready) begin
                bus.req_valid  = 1'b1;
                bus.req_type   = 2'(nty);
                bus.req_rot    = 2'(nrot);
                bus.req_mirror = nmir;
                bus.req_row    = 3'(nrow);
            end
            #1;
            chk1("pix_valid", bus.pix_valid, 1'b1);
            chk1("pix_last", bus.pix_last, col == 7);
            chk1("pix_out", bus.pix_out, exp[7-col]);
            chk1("shift_req_ready", bus.req_ready, (col == 7) && bus.pix_ready);
            if (bus.pix_ready) col++;
            k++;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end
        chk1("row_complete", col >= npix, 1'b1);
        if (npix == 8 && !chain) begin
            chk1("end_pix_valid", bus.pix_valid, 1'b0);
            chk1("end_req_ready", bus.req_ready, 1'b1);
        end
    endtask

    initial begin
        int         ty, rot, row, ty2, rot2, row2;
        bit         mir, mir2;
        logic [7:0] e1, e2;

        bus.req_valid  = 1'b0;
        bus.req_type   = '0;
        bus.req_rot    = '0;
        bus.req_mirror = 1'b0;
        bus.req_row    = '0;
        bus.pix_ready  = 1'b0;
        reset_n        = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk1("rst_pix_valid", bus.pix_valid, 1'b0);
        chk1("rst_pix_out", bus.pix_out, 1'b0);
        chk1("rst_pix_last", bus.pix_last, 1'b0);
        #19 reset_n = 1'b1;
        @(posedge clk); #1;
        chk1("post_rst_req_ready", bus.req_ready, 1'b1);
        chk1("post_rst_pix_valid", bus.pix_valid, 1'b0);

        request(1, 0, 0, 0); pixels(8'b0001_0000, 0, 8, 0, 0, 0, 0, 0);
        request(1, 1, 0, 3); pixels(8'b1111_1111, 0, 8, 0, 0, 0, 0, 0);
        request(1, 1, 0, 0); pixels(8'b0000_0000, 0, 8, 0, 0, 0, 0, 0);
        request(1, 1, 0, 7); pixels(8'b0000_0000, 0, 8, 0, 0, 0, 0, 0);
        request(2, 2, 0, 4); pixels(8'b1110_0000, 0, 8, 0, 0, 0, 0, 0);
        request(2, 2, 1, 4); pixels(8'b0000_0111, 0, 8, 0, 0, 0, 0, 0);

        // Back-to-back rows with no bubble
        request(2, 0, 0, 3); pixels(8'b0000_0111, 0, 8, 1, 2, 0, 0, 4);
        pixels(8'b0000_1000, 0, 8, 0, 0, 0, 0, 0);

        // Consumer stalls mid-row
        request(3, 0, 0, 4); pixels(8'b0000_0011, 2, 8, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ty  = int'($urandom_range(0, 3));
            rot = int'($urandom_range(0, 3));
            mir = bit'($urandom_range(0, 1));
            row = int'($urandom_range(0, 7));
            request(ty, rot, mir, row);
            pixels(model_row(ty, rot, mir, row), 1, 8, 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < 10; i++) begin
            ty   = int'($urandom_range(0, 3));
            rot  = int'($urandom_range(0, 3));
            mir  = bit'($urandom_range(0, 1));
            row  = int'($urandom_range(0, 7));
            ty2  = int'($urandom_range(0, 3));
            rot2 = int'($urandom_range(0, 3));
            mir2 = bit'($urandom_range(0, 1));
            row2 = int'($urandom_range(0, 7));
            e1   = model_row(ty, rot, mir, row);
            e2   = model_row(ty2, rot2, mir2, row2);
            request(ty, rot, mir, row);
            pixels(e1, 1, 8, 1, ty2, rot2, mir2, row2);
            pixels(e2, 1, 8, 0, 0, 0, 0, 0);
        end

        // Reset in the middle of a row
        request(1, 1, 0, 3); pixels(8'b1111_1111, 0, 4, 0, 0, 0, 0, 0);
        bus.pix_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk1("midrst_pix_valid", bus.pix_valid, 1'b0);
        chk1("midrst_pix_out", bus.pix_out, 1'b0);
        chk1("midrst_pix_last", bus.pix_last, 1'b0);
        #5 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1("after_rst_req_ready", bus.req_ready, 1'b1);
            chk1("after_rst_pix_valid", bus.pix_valid, 1'b0);
        end
        request(3, 3, 1, 5); pixels(model_row(3, 3, 1, 5), 0, 8, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
